// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants, operand-use decode and sequencer state encoding
package cpu_pkg;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_LHB = 4'b1011;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  function automatic logic uses_rs(input logic [3:0] op);
    return !(op == OP_LLB || op == OP_LHB || op == OP_B || op == OP_HLT);
  endfunction

  // ALU ops occupy 0000-0111; SW additionally reads its store data from rt
  function automatic logic uses_rt(input logic [3:0] op);
    return (op < OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_branch_reg(input logic [3:0] op);
    return op == OP_BR;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// rtl/hazard_decode.sv - combinational load-use and HLT detection for the ID stage
module hazard_decode
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  input  logic        memread,
  input  logic [3:0]  rd,
  output logic        load_use,
  output logic        is_hlt
);

  logic [3:0] op;
  logic [3:0] rs;
  logic [3:0] rt;
  logic       rs_hit;
  logic       rt_hit;
  logic       unused_bits;

  assign op          = instr[15:12];
  assign rs          = instr[7:4];
  assign rt          = instr[3:0];
  assign unused_bits = ^instr[11:8];

  assign rs_hit = uses_rs(op) && (rs == rd);
  assign rt_hit = uses_rt(op) && (rt == rd);

  // R0 is hardwired zero, so a load targeting it never needs a bubble
  assign load_use = memread && (rd != 4'd0) && (rs_hit || rt_hit);
  assign is_hlt   = (op == OP_HLT);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer with HLT drain and saturating stall counter
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int HLT_DRAIN = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      if_id_instr,
  input  logic             id_ex_memread,
  input  logic [3:0]       id_ex_rd,
  input  logic             branch_taken,
  input  logic             icache_busy,
  input  logic             dcache_busy,
  output logic             pc_wen,
  output logic             if_id_wen,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             back_wen,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int DW = (HLT_DRAIN < 2) ? 1 : $clog2(HLT_DRAIN + 1);

  state_t        state;
  state_t        next_state;
  logic [DW-1:0] drain_cnt;
  logic [DW-1:0] next_cnt;
  logic          load_use;
  logic          is_hlt;

  hazard_decode u_hazard (
    .instr    (if_id_instr),
    .memread  (id_ex_memread),
    .rd       (id_ex_rd),
    .load_use (load_use),
    .is_hlt   (is_hlt)
  );

  always_comb begin
    pc_wen      = 1'b0;
    if_id_wen   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    back_wen    = 1'b0;
    halted      = 1'b0;
    next_state  = state;
    next_cnt    = drain_cnt;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      next_state  = ST_RUN;
      next_cnt    = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (dcache_busy) begin
            // full freeze: nothing moves, nothing is flushed
          end else if (load_use) begin
            id_ex_flush = 1'b1;
            back_wen    = 1'b1;
          end else if (is_hlt) begin
            back_wen   = 1'b1;
            next_state = ST_DRAIN;
            next_cnt   = DW'(HLT_DRAIN);
          end else if (branch_taken) begin
            pc_wen      = 1'b1;
            if_id_wen   = 1'b1;
            if_id_flush = 1'b1;
            back_wen    = 1'b1;
          end else if (icache_busy) begin
            if_id_wen   = 1'b1;
            if_id_flush = 1'b1;
            back_wen    = 1'b1;
          end else begin
            pc_wen    = 1'b1;
            if_id_wen = 1'b1;
            back_wen  = 1'b1;
          end
        end
        ST_DRAIN: begin
          if_id_flush = 1'b1;
          back_wen    = !dcache_busy;
          if (back_wen) begin
            next_cnt = drain_cnt - 1'b1;
            if (drain_cnt == DW'(1)) next_state = ST_HALTED;
          end
        end
        ST_HALTED: halted = 1'b1;
        default:   next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      drain_cnt    <= '0;
      stall_cycles <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_cnt;
      if (!pc_wen && state != ST_HALTED && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - table-driven scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] if_id_instr = 16'h0000;
  logic        id_ex_memread = 1'b0;
  logic [3:0]  id_ex_rd = 4'd0;
  logic        branch_taken = 1'b0;
  logic        icache_busy = 1'b0;
  logic        dcache_busy = 1'b0;

  logic        pc_wen, if_id_wen, if_id_flush, id_ex_flush, back_wen, halted;
  logic [15:0] stall_cycles;
  logic        pc_wen4, if_id_wen4, if_id_flush4, id_ex_flush4, back_wen4, halted4;
  logic [3:0]  stall_cycles4;

  always #5 clk = ~clk;

  pipeline_ctrl #(.HLT_DRAIN(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .id_ex_memread(id_ex_memread),
    .id_ex_rd(id_ex_rd), .branch_taken(branch_taken), .icache_busy(icache_busy),
    .dcache_busy(dcache_busy), .pc_wen(pc_wen), .if_id_wen(if_id_wen),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .back_wen(back_wen),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.HLT_DRAIN(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .id_ex_memread(id_ex_memread),
    .id_ex_rd(id_ex_rd), .branch_taken(branch_taken), .icache_busy(icache_busy),
    .dcache_busy(dcache_busy), .pc_wen(pc_wen4), .if_id_wen(if_id_wen4),
    .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4), .back_wen(back_wen4),
    .halted(halted4), .stall_cycles(stall_cycles4)
  );

  // exp bits: {pc_wen, if_id_wen, if_id_flush, id_ex_flush, back_wen, halted}
  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        memread;
    logic [3:0]  rd;
    logic        br;
    logic        ic;
    logic        dc;
    logic [5:0]  exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [5:0]  exp;
    logic [15:0] stall;
    string       name;
  } sb_t;

  localparam logic [5:0] E_RUN   = 6'b110010;
  localparam logic [5:0] E_LU    = 6'b000110;
  localparam logic [5:0] E_FRZ   = 6'b000000;
  localparam logic [5:0] E_BR    = 6'b111010;
  localparam logic [5:0] E_IC    = 6'b011010;
  localparam logic [5:0] E_HLT   = 6'b000010;
  localparam logic [5:0] E_DRN   = 6'b001010;
  localparam logic [5:0] E_DRNF  = 6'b001000;
  localparam logic [5:0] E_HALT  = 6'b000001;
  localparam logic [5:0] E_RESET = 6'b001100;

  int   checks = 0;
  int   errors = 0;
  sb_t  sbq[$];
  logic [15:0] exp_stall = 16'd0;
  vec_t tbl[18];

  function automatic vec_t mk(input logic r, input logic [15:0] i, input logic m,
                              input logic [3:0] d, input logic b, input logic ic,
                              input logic dc, input logic [5:0] e, input string n);
    vec_t v;
    v.rst = r; v.instr = i; v.memread = m; v.rd = d;
    v.br = b; v.ic = ic; v.dc = dc; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic check_out();
    sb_t s;
    logic [5:0] act;
    if (sbq.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    s = sbq.pop_front();
    act = {pc_wen, if_id_wen, if_id_flush, id_ex_flush, back_wen, halted};
    checks++;
    if (act !== s.exp) begin
      errors++;
      $display("FAIL %s outputs: got %b expected %b", s.name, act, s.exp);
    end
    checks++;
    if (stall_cycles !== s.stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", s.name, stall_cycles, s.stall);
    end
  endtask

  task automatic apply(input vec_t v);
    sb_t s;
    @(posedge clk); #1;
    rst = v.rst; if_id_instr = v.instr; id_ex_memread = v.memread; id_ex_rd = v.rd;
    branch_taken = v.br; icache_busy = v.ic; dcache_busy = v.dc;
    s.exp = v.exp; s.stall = exp_stall; s.name = v.name;
    sbq.push_back(s);
    if (v.rst) exp_stall = 16'd0;
    else if (!v.exp[5] && !v.exp[0]) exp_stall = exp_stall + 16'd1;
    @(negedge clk);
    check_out();
  endtask

  task automatic check4(input logic [3:0] want, input string n);
    checks++;
    if (stall_cycles4 !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, stall_cycles4, want);
    end
  endtask

  initial begin
    tbl[0]  = mk(0, 16'h0352, 0, 4'd0, 0, 0, 0, E_RUN, "idle_add");
    tbl[1]  = mk(0, 16'h0352, 1, 4'd5, 0, 0, 0, E_LU,  "lu_rs");
    tbl[2]  = mk(0, 16'h0352, 0, 4'd5, 0, 0, 0, E_RUN, "lu_cleared");
    tbl[3]  = mk(0, 16'h0352, 1, 4'd2, 0, 0, 0, E_LU,  "lu_rt");
    tbl[4]  = mk(0, 16'h0300, 1, 4'd0, 0, 0, 0, E_RUN, "r0_exempt");
    tbl[5]  = mk(0, 16'hA352, 1, 4'd5, 0, 0, 0, E_RUN, "llb_no_rs");
    tbl[6]  = mk(0, 16'h9352, 1, 4'd2, 0, 0, 0, E_LU,  "sw_uses_rt");
    tbl[7]  = mk(0, 16'h8352, 1, 4'd2, 0, 0, 0, E_RUN, "lw_no_rt");
    tbl[8]  = mk(0, 16'hD050, 1, 4'd5, 0, 0, 0, E_LU,  "br_uses_rs");
    tbl[9]  = mk(0, 16'hC350, 1, 4'd5, 0, 0, 0, E_RUN, "b_no_rs");
    tbl[10] = mk(0, 16'h0000, 0, 4'd0, 1, 1, 0, E_BR,  "branch_beats_icache");
    tbl[11] = mk(0, 16'h0000, 0, 4'd0, 0, 1, 0, E_IC,  "icache_bubble");
    tbl[12] = mk(0, 16'h0352, 1, 4'd5, 1, 0, 0, E_LU,  "lu_beats_branch");
    tbl[13] = mk(0, 16'h0352, 1, 4'd5, 0, 0, 1, E_FRZ, "dc_freeze_lu_1");
    tbl[14] = mk(0, 16'h0352, 1, 4'd5, 0, 1, 1, E_FRZ, "dc_freeze_lu_2");
    tbl[15] = mk(0, 16'h0352, 1, 4'd5, 1, 0, 1, E_FRZ, "dc_freeze_lu_3");
    tbl[16] = mk(0, 16'h0352, 1, 4'd5, 0, 0, 0, E_LU,  "lu_after_freeze");
    tbl[17] = mk(0, 16'h0352, 0, 4'd5, 0, 0, 0, E_RUN, "run_after_lu");

    repeat (2) @(posedge clk);
    apply(mk(1, 16'h0352, 1, 4'd5, 1, 1, 0, E_RESET, "reset_outputs"));

    for (int i = 0; i < 18; i++) apply(tbl[i]);

    // HLT drain with a one-cycle dcache hold inside DRAIN
    apply(mk(1, 16'h0000, 0, 4'd0, 0, 0, 0, E_RESET, "reset_before_hlt"));
    apply(mk(0, 16'hF000, 0, 4'd0, 0, 0, 0, E_HLT,  "hlt_in_id"));
    apply(mk(0, 16'hF000, 0, 4'd0, 1, 1, 1, E_DRNF, "drain_dc_hold"));
    apply(mk(0, 16'h0000, 0, 4'd0, 1, 0, 0, E_DRN,  "drain_3"));
    apply(mk(0, 16'h0000, 0, 4'd0, 0, 1, 0, E_DRN,  "drain_2"));
    apply(mk(0, 16'h0000, 0, 4'd0, 0, 0, 0, E_DRN,  "drain_1"));
    apply(mk(0, 16'h0000, 0, 4'd0, 0, 0, 0, E_HALT, "halted_5_after"));
    apply(mk(0, 16'h0352, 1, 4'd5, 1, 1, 1, E_HALT, "halted_sticky"));
    apply(mk(1, 16'h0000, 0, 4'd0, 0, 0, 0, E_RESET, "reset_from_halt"));
    apply(mk(0, 16'h0000, 0, 4'd0, 0, 0, 0, E_RUN,  "run_after_halt_reset"));

    // reset in the middle of DRAIN leaves no residual freeze
    apply(mk(0, 16'hF000, 0, 4'd0, 0, 0, 0, E_HLT,  "hlt_again"));
    apply(mk(0, 16'h0000, 0, 4'd0, 0, 0, 0, E_DRN,  "drain_then_reset"));
    apply(mk(1, 16'h0000, 0, 4'd0, 0, 0, 0, E_RESET, "reset_mid_drain"));
    apply(mk(0, 16'h0000, 0, 4'd0, 0, 0, 0, E_RUN,  "run_after_drain_reset"));

    // saturation of the 4-bit counter instance
    apply(mk(1, 16'h0000, 0, 4'd0, 0, 0, 0, E_RESET, "reset_before_sat"));
    check4(4'd0, "sat_reset_value");
    for (int i = 0; i < 20; i++)
      apply(mk(0, 16'h0000, 0, 4'd0, 0, 1, 0, E_IC, "icache_hold"));
    check4(4'd15, "sat_reaches_max");
    apply(mk(0, 16'h0000, 0, 4'd0, 0, 1, 0, E_IC, "icache_hold_more"));
    check4(4'd15, "sat_holds_max");

    if (sbq.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_leftover: %0d entries", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB). It arbitrates four competing hold-up sources: data-cache busy, instruction-cache busy, load-use hazard and taken branch. It also sequences the HLT drain. From these it drives per-stage pipeline-register write enables and flushes, and a halted flag. It sits beside the ID stage and replaces ad-hoc stall logic scattered across stages.

Parameters:
HLT_DRAIN, 3, cycles spent in DRAIN after HLT leaves ID, so EX/MEM/WB retire.
CNT_W, 16, width of saturating stall-cycle counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_id_instr  in  16  instruction currently in ID
id_ex_memread  in  1  instruction in EX is a load
id_ex_rd  in  4  destination register of instruction in EX
branch_taken  in  1  ID resolved a taken B/BR this cycle
icache_busy  in  1  instruction fetch not complete
dcache_busy  in  1  data access in MEM not complete
pc_wen  out  1  PC update enable
if_id_wen  out  1  IF/ID register write enable
if_id_flush  out  1  load NOP into IF/ID
id_ex_flush  out  1  load NOP into ID/EX
back_wen  out  1  ID/EX, EX/MEM and MEM/WB write enable
halted  out  1  processor halted
stall_cycles  out  CNT_W  count of cycles with pc_wen==0 while not halted

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset -> RUN and drain counter=0. Reset outputs: pc_wen=0, if_id_wen=0, if_id_flush=1, id_ex_flush=1, back_wen=0, halted=0, stall_cycles=0. All outputs are registered-state-derived or combinational from current inputs. No output depends on pre-reset history.
- Operand use decoded from if_id_instr[15:12]:
  - rs=[7:4] is read by all opcodes except LLB(1010), LHB(1011), B(1100), HLT(1111).
  - rt=[3:0] is read by 0000-0111 and SW(1001).
- load_use = id_ex_memread & id_ex_rd!=0 & ((uses_rs & rs==id_ex_rd) | (uses_rt & rt==id_ex_rd)). R0 never hazards.
- RUN priority, highest first; exactly one row applies per cycle:
  1. dcache_busy: freeze everything. pc_wen=0, if_id_wen=0, back_wen=0, no flushes.
  2. load_use: pc_wen=0, if_id_wen=0, id_ex_flush=1, back_wen=1 (one bubble per cycle while the hazard persists).
  3. HLT in ID: pc_wen=0, if_id_wen=0, back_wen=1. HLT passes into ID/EX unflushed. Next state DRAIN, counter=HLT_DRAIN.
  4. branch_taken: pc_wen=1, if_id_flush=1, back_wen=1. icache_busy is ignored this cycle because the redirect wins.
  5. icache_busy: pc_wen=0, if_id_flush=1 (bubble into ID), back_wen=1.
  6. otherwise all write enables=1, no flushes.
- DRAIN:
  - pc_wen=0, if_id_wen=0, if_id_flush=1, back_wen=!dcache_busy.
  - Counter decrements only when back_wen=1.
  - At counter==1 with back_wen=1 -> HALTED. HLT_DRAIN=0 is illegal.
  - branch_taken and icache_busy are ignored in DRAIN.
- HALTED: all write enables=0, flushes=0, halted=1. Leaves only on rst.
- stall_cycles:
  - Increments when pc_wen==0 and state!=HALTED.
  - Saturates at all-ones and does not wrap.
  - Reset to 0.
- Reset mid-DRAIN or mid-stall: the next cycle is RUN with reset outputs; there is no residual freeze.
- dcache_busy and load_use together: dcache freeze wins. load_use is re-evaluated after the freeze.

Decomposition:
- Shared package cpu_pkg:
  - 4-bit opcode constants (OP_LW=1000, OP_SW=1001, OP_LLB, OP_LHB, OP_B, OP_BR, OP_HLT).
  - Functions uses_rs(op) and uses_rt(op).
  - FSM state encoding.
- One natural sub-module, hazard_decode: purely combinational load_use and HLT detection from if_id_instr, id_ex_memread and id_ex_rd. FSM, priority mux and counter stay in pipeline_ctrl.

Test Plan:
- Load-use: ID=ADD R3,R5,R2 (0x0352); EX load with rd=5, memread=1 -> one cycle pc_wen=0, if_id_wen=0, id_ex_flush=1. Next cycle with memread=0 -> all enables=1. stall_cycles=1.
- R0 exemption: ID rs=0, EX load rd=0 -> no stall, all enables=1.
- Taken branch with icache_busy=1 same cycle -> pc_wen=1, if_id_flush=1. Next cycle with icache_busy=1, branch_taken=0 -> pc_wen=0, if_id_flush=1.
- dcache_busy=1 for 3 cycles during load_use -> back_wen=0, no flushes, stall_cycles+=3. Then the load_use bubble follows.
- HLT (0xF000) in ID with HLT_DRAIN=3 and dcache_busy pulsed 1 cycle in DRAIN -> halted=1 exactly 5 cycles after HLT entered ID. pc_wen stays 0 throughout. rst then -> RUN, halted=0, stall_cycles=0.
- Saturation: force CNT_W=4, hold icache_busy 20 cycles -> stall_cycles=15 and holds.
